// File: rtl/alu_multicycle.sv
// Multi-cycle ALU for the MIPS execute stage: valid/ready on both sides,
// single-cycle logic/arith ops, and bit-serial unsigned multiply/divide.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             div_by_zero
);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101,
                           OP_MUL = 3'b110, OP_DIV = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fin_q, fin_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d;
    logic                 zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]     add_r, sub_r, sc_res;
    logic                 sc_ovf;
    logic [WIDTH:0]       mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0]   mul_step, div_step;

    assign add_r = a_in + b_in;
    assign sub_r = a_in - b_in;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = add_r;
                sc_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_r[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_r;
                sc_ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_r[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND:  sc_res = a_in & b_in;
            OP_OR:   sc_res = a_in | b_in;
            OP_XOR:  sc_res = a_in ^ b_in;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            default: sc_res = '0;
        endcase
    end

    // Multiply: acc = {partial high (with carry), remaining multiplier}, shifted right.
    // Divide: acc = {remainder, dividend bits shifting out / quotient bits in}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, opnd_q};
    assign div_step = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        div_d   = div_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = CNT_W'(WIDTH-1);
                    fin_d = 1'b0;
                    if (op == OP_MUL) begin
                        state_d = S_ITER;
                        div_d   = 1'b0;
                        opnd_d  = a_in;
                        acc_d   = {{WIDTH{1'b0}}, b_in};
                    end else if (op == OP_DIV && b_in != '0) begin
                        state_d = S_ITER;
                        div_d   = 1'b1;
                        opnd_d  = b_in;
                        acc_d   = {{WIDTH{1'b0}}, a_in};
                    end else if (op == OP_DIV) begin
                        state_d = S_DONE;
                        res_d   = '1;
                        hi_d    = a_in;
                        zero_d  = 1'b0;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        res_d   = sc_res;
                        hi_d    = '0;
                        zero_d  = (sc_res == '0);
                        ovf_d   = sc_ovf;
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_ITER: begin
                // One extra cycle after the last step moves acc into the result regs.
                if (!fin_q) begin
                    acc_d = div_q ? div_step : mul_step;
                    if (cnt_q == '0) fin_d = 1'b1;
                    else             cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    res_d   = acc_q[WIDTH-1:0];
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_q[WIDTH-1:0] == '0);
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            div_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            div_q   <= div_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = res_q;
    assign result_hi   = hi_q;
    assign zero        = zero_q;
    assign ovf         = ovf_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: hand-computed vectors, immediate assertions.
module tb_alu_multicycle;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         in_ready, out_valid, zero, ovf, div_by_zero;
    logic [W-1:0] result, result_hi;

    int n_total = 0;
    int n_pass  = 0;

    alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .zero(zero), .ovf(ovf), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present an op for one cycle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Expects out_valid=0/in_ready=0 for 33 samples, then out_valid=1 (33 cycles after accept).
    task automatic wait_long(input string tag);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 33; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_busy"}, {63'b0, bad}, 64'd0);
        chk({tag, "_latency"}, {63'b0, out_valid}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] h_res, h_hi;
        logic         h_bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_flags", {61'b0, zero, ovf, div_by_zero}, 64'd0);
        rst = 1'b0;

        // ADD overflow
        start_op(3'b000, 32'h7FFF_FFFF, 32'h1);
        chk("add_valid", {63'b0, out_valid}, 64'd1);
        chk("add_result", {32'b0, result}, 64'h8000_0000);
        chk("add_hi", {32'b0, result_hi}, 64'd0);
        chk("add_flags", {61'b0, zero, ovf, div_by_zero}, 64'b010);
        finish_op();

        start_op(3'b001, 32'd5, 32'd5);
        chk("sub_result", {32'b0, result}, 64'd0);
        chk("sub_flags", {61'b0, zero, ovf, div_by_zero}, 64'b100);
        finish_op();

        start_op(3'b001, 32'h8000_0000, 32'd1);
        chk("sub_ovf_result", {32'b0, result}, 64'h7FFF_FFFF);
        chk("sub_ovf_flag", {63'b0, ovf}, 64'd1);
        finish_op();

        start_op(3'b101, 32'hFFFF_FFFF, 32'd1);
        chk("slt_result", {32'b0, result}, 64'd1);
        finish_op();

        start_op(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
        chk("and_result", {32'b0, result}, 64'h0000_F000);
        finish_op();

        start_op(3'b011, 32'h1200_0034, 32'h0056_7800);
        chk("or_result", {32'b0, result}, 64'h1256_7834);
        finish_op();

        // MULU
        start_op(3'b110, 32'hFFFF_FFFF, 32'd2);
        wait_long("mulu");
        chk("mulu_lo", {32'b0, result}, 64'hFFFF_FFFE);
        chk("mulu_hi", {32'b0, result_hi}, 64'd1);
        finish_op();

        start_op(3'b110, 32'd12345, 32'd6789);
        wait_long("mulu2");
        chk("mulu2_full", {result_hi, result}, 64'd83810205);
        finish_op();

        // DIVU
        start_op(3'b111, 32'd100, 32'd7);
        wait_long("divu");
        chk("divu_q", {32'b0, result}, 64'd14);
        chk("divu_r", {32'b0, result_hi}, 64'd2);
        chk("divu_dbz", {63'b0, div_by_zero}, 64'd0);
        finish_op();

        start_op(3'b111, 32'hFFFF_FFFF, 32'h0001_0000);
        wait_long("divu2");
        chk("divu2_qr", {result_hi, result}, {32'h0000_FFFF, 32'h0000_FFFF});
        finish_op();

        start_op(3'b111, 32'd5, 32'd0);
        chk("dbz_valid", {63'b0, out_valid}, 64'd1);
        chk("dbz_result", {32'b0, result}, 64'hFFFF_FFFF);
        chk("dbz_hi", {32'b0, result_hi}, 64'd5);
        chk("dbz_flag", {63'b0, div_by_zero}, 64'd1);
        finish_op();

        // XOR held in DONE while new inputs are offered
        start_op(3'b100, 32'hAAAA_5555, 32'h0F0F_0F0F);
        chk("xor_result", {32'b0, result}, 64'hA5A5_5A5A);
        h_res = result; h_hi = result_hi; h_bad = 1'b0;
        in_valid = 1'b1; op = 3'b000; a_in = 32'd1; b_in = 32'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== h_res ||
                result_hi !== h_hi || zero !== 1'b0) h_bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("hold_stable", {63'b0, h_bad}, 64'd0);
        chk("hold_value", {32'b0, result}, 64'hA5A5_5A5A);
        finish_op();
        chk("release_in_ready", {63'b0, in_ready}, 64'd1);
        chk("release_out_valid", {63'b0, out_valid}, 64'd0);

        // Reset during MULU iteration
        start_op(3'b110, 32'd1000, 32'd1000);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {63'b0, in_ready}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_result", {result_hi, result}, 64'd0);
        start_op(3'b000, 32'd3, 32'd4);
        chk("post_rst_add", {32'b0, result}, 64'd7);
        chk("post_rst_valid", {63'b0, out_valid}, 64'd1);
        finish_op();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
